// File: rtl/rom_arb_if.sv
// Host/ROM bundle for rom_arb_ctrl: two read hosts in, one ROM port out, plus the response error flag.
interface rom_arb_if #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 2048
);
   localparam int unsigned Aw = $clog2(Depth);

   logic             h0_req_i;
   logic [Aw-1:0]    h0_addr_i;
   logic             h0_gnt_o;
   logic             h0_rvalid_o;
   logic [Width-1:0] h0_rdata_o;
   logic             h1_req_i;
   logic [Aw-1:0]    h1_addr_i;
   logic             h1_gnt_o;
   logic             h1_rvalid_o;
   logic [Width-1:0] h1_rdata_o;
   logic             rom_req_o;
   logic [Aw-1:0]    rom_addr_o;
   logic             rom_rvalid_i;
   logic [Width-1:0] rom_rdata_i;
   logic             rsp_err_o;

   modport slave (
      input  h0_req_i, h0_addr_i, h1_req_i, h1_addr_i, rom_rvalid_i, rom_rdata_i,
      output h0_gnt_o, h0_rvalid_o, h0_rdata_o, h1_gnt_o, h1_rvalid_o, h1_rdata_o,
             rom_req_o, rom_addr_o, rsp_err_o
   );

   modport master (
      output h0_req_i, h0_addr_i, h1_req_i, h1_addr_i, rom_rvalid_i, rom_rdata_i,
      input  h0_gnt_o, h0_rvalid_o, h0_rdata_o, h1_gnt_o, h1_rvalid_o, h1_rdata_o,
             rom_req_o, rom_addr_o, rsp_err_o
   );
endinterface

// File: rtl/rom_arb_ctrl.sv
// Two-host ROM arbiter: host 0 (TL-UL) normally wins, host 1 (integrity checker) gets a
// bounded-starvation override; responses are routed back by a one-deep ownership tag.
module rom_arb_ctrl #(
   parameter int unsigned Width   = 32,
   parameter int unsigned Depth   = 2048,
   parameter int unsigned MaxWait = 8
) (
   input logic        clk_i,
   input logic        rst_ni,
   rom_arb_if.slave   bus
);
   localparam int unsigned Aw   = $clog2(Depth);
   localparam int unsigned CntW = $clog2(MaxWait + 1);

   logic [CntW-1:0]  wait_cnt_q;
   logic             tag_vld_q;
   logic             tag_own_q;
   logic             h1_starved;
   logic             h0_win;
   logic             h1_win;
   logic [Aw-1:0]    win_addr;
   logic             rsp_ok;
   logic [Width-1:0] rsp_data;

   assign h1_starved = bus.h1_req_i && (wait_cnt_q == CntW'(MaxWait));

   always_comb begin
      h1_win   = 1'b0;
      h0_win   = 1'b0;
      win_addr = '0;
      if (bus.h1_req_i && (h1_starved || !bus.h0_req_i)) begin
         h1_win   = 1'b1;
         win_addr = bus.h1_addr_i;
      end else if (bus.h0_req_i) begin
         h0_win   = 1'b1;
         win_addr = bus.h0_addr_i;
      end
   end

   assign bus.h0_gnt_o   = h0_win;
   assign bus.h1_gnt_o   = h1_win;
   assign bus.rom_req_o  = h0_win | h1_win;
   assign bus.rom_addr_o = win_addr;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wait_cnt_q <= '0;
         tag_vld_q  <= 1'b0;
         tag_own_q  <= 1'b0;
      end else begin
         if (!bus.h1_req_i || h1_win) begin
            wait_cnt_q <= '0;
         end else if (wait_cnt_q != CntW'(MaxWait)) begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
         end
         tag_vld_q <= h0_win | h1_win;
         tag_own_q <= h1_win;
      end
   end

   // Data is gated per host so one host never observes the other's ROM word.
   assign rsp_ok   = bus.rom_rvalid_i && tag_vld_q;
   assign rsp_data = bus.rom_rdata_i;

   assign bus.h0_rvalid_o = rsp_ok && !tag_own_q;
   assign bus.h1_rvalid_o = rsp_ok &&  tag_own_q;
   assign bus.h0_rdata_o  = (rsp_ok && !tag_own_q) ? rsp_data : '0;
   assign bus.h1_rdata_o  = (rsp_ok &&  tag_own_q) ? rsp_data : '0;
   assign bus.rsp_err_o   = bus.rom_rvalid_i ^ tag_vld_q;

   a_req_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !$isunknown({bus.h0_req_i, bus.h1_req_i}));
   a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.h0_gnt_o && bus.h1_gnt_o));
   a_h0_rsp_granted : assert property (@(posedge clk_i) disable iff (!rst_ni)
      bus.h0_rvalid_o |-> $past(bus.h0_gnt_o));
   a_h1_rsp_granted : assert property (@(posedge clk_i) disable iff (!rst_ni)
      bus.h1_rvalid_o |-> $past(bus.h1_gnt_o));
endmodule

// File: tb/tb_rom_arb_ctrl.sv
// Directed bench for rom_arb_ctrl with a one-cycle ROM model and a response scoreboard.
module tb_rom_arb_ctrl;
   localparam int unsigned Width = 32;
   localparam int unsigned Depth = 2048;
   localparam int unsigned Aw    = $clog2(Depth);

   typedef struct {
      bit          vld;
      bit          host;
      logic [31:0] data;
      bit          err;
   } exp_t;

   logic clk_i;
   logic rst_ni;
   logic drop_next;
   logic inject;
   logic             rv_q;
   logic [Width-1:0] rd_q;
   exp_t sb[$];
   int   n_cmp;
   int   n_bad;

   rom_arb_if #(.Width(Width), .Depth(Depth)) bus ();

   rom_arb_ctrl #(.Width(Width), .Depth(Depth), .MaxWait(8)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] rom_word(input logic [Aw-1:0] a);
      return {5'h1A, a, 16'h5A5A};
   endfunction

   // ROM wrapper model: registered rvalid one cycle after a request, resets with the arbiter.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rv_q <= 1'b0;
         rd_q <= '0;
      end else begin
         rv_q <= bus.rom_req_o & ~drop_next;
         rd_q <= rom_word(bus.rom_addr_o);
      end
   end
   assign bus.rom_rvalid_i = rv_q | inject;
   assign bus.rom_rdata_i  = rd_q;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit r0, input logic [Aw-1:0] a0, input bit r1, input logic [Aw-1:0] a1,
                      input bit eg0, input bit eg1, input string tag,
                      input bit drop = 1'b0, input bit inj = 1'b0);
      exp_t e;
      exp_t n;
      logic [Aw-1:0] wa;
      bus.h0_req_i  = r0;
      bus.h0_addr_i = a0;
      bus.h1_req_i  = r1;
      bus.h1_addr_i = a1;
      drop_next     = drop;
      inject        = inj;
      #1;
      if (sb.size() > 0) e = sb.pop_front();
      else e = '{vld: 1'b0, host: 1'b0, data: 32'h0, err: 1'b0};
      if (inj) e.err = 1'b1;
      chk({tag, ".h0_rvalid"}, 64'(bus.h0_rvalid_o), 64'(e.vld && !e.host));
      chk({tag, ".h1_rvalid"}, 64'(bus.h1_rvalid_o), 64'(e.vld && e.host));
      chk({tag, ".h0_rdata"},  64'(bus.h0_rdata_o),  64'((e.vld && !e.host) ? e.data : 32'h0));
      chk({tag, ".h1_rdata"},  64'(bus.h1_rdata_o),  64'((e.vld && e.host) ? e.data : 32'h0));
      chk({tag, ".rsp_err"},   64'(bus.rsp_err_o),   64'(e.err));
      chk({tag, ".h0_gnt"},    64'(bus.h0_gnt_o),    64'(eg0));
      chk({tag, ".h1_gnt"},    64'(bus.h1_gnt_o),    64'(eg1));
      chk({tag, ".rom_req"},   64'(bus.rom_req_o),   64'(eg0 | eg1));
      wa = eg1 ? a1 : (eg0 ? a0 : '0);
      chk({tag, ".rom_addr"},  64'(bus.rom_addr_o),  64'(wa));
      n.vld  = (eg0 | eg1) & ~drop;
      n.host = eg1;
      n.data = rom_word(wa);
      n.err  = drop;
      sb.push_back(n);
      @(posedge clk_i);
      #1;
      inject    = 1'b0;
      drop_next = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_ni        = 1'b0;
      drop_next     = 1'b0;
      inject        = 1'b0;
      bus.h0_req_i  = 1'b0;
      bus.h0_addr_i = '0;
      bus.h1_req_i  = 1'b0;
      bus.h1_addr_i = '0;
      #2;
      chk("rst.rom_req",   64'(bus.rom_req_o),   64'h0);
      chk("rst.rom_addr",  64'(bus.rom_addr_o),  64'h0);
      chk("rst.gnt",       64'({bus.h0_gnt_o, bus.h1_gnt_o}), 64'h0);
      chk("rst.rvalid",    64'({bus.h0_rvalid_o, bus.h1_rvalid_o}), 64'h0);
      chk("rst.rsp_err",   64'(bus.rsp_err_o),   64'h0);
      chk("rst.wait_cnt",  64'(dut.wait_cnt_q),  64'h0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      sb.push_back('{vld: 1'b0, host: 1'b0, data: 32'h0, err: 1'b0});

      // single host-0 read
      cyc(1'b1, 11'h010, 1'b0, 11'h000, 1'b1, 1'b0, "single");
      cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, "single_rsp");

      // both hosts saturating: host 1 wins every ninth cycle
      for (int i = 0; i < 27; i++) begin
         cyc(1'b1, Aw'(11'h100 + i), 1'b1, Aw'(11'h200 + i / 9),
             (i % 9) != 8, (i % 9) == 8, $sformatf("starve%0d", i));
      end
      cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, "starve_rsp");

      // alternating owners with no bubbles
      cyc(1'b1, 11'h001, 1'b0, 11'h000, 1'b1, 1'b0, "alt0");
      cyc(1'b0, 11'h000, 1'b1, 11'h002, 1'b0, 1'b1, "alt1");
      cyc(1'b1, 11'h003, 1'b0, 11'h000, 1'b1, 1'b0, "alt2");
      cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, "alt_rsp");

      // unexpected response
      cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, "idle");
      cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, "inject", 1'b0, 1'b1);
      cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, "inject_after");

      // missing response on a host-1 read, then a normal one
      cyc(1'b0, 11'h000, 1'b1, 11'h055, 1'b0, 1'b1, "drop", 1'b1);
      cyc(1'b0, 11'h000, 1'b1, 11'h056, 1'b0, 1'b1, "drop_next");
      cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, "drop_rsp");

      // reset with a read in flight and host 1 partly starved
      cyc(1'b1, 11'h030, 1'b1, 11'h031, 1'b1, 1'b0, "mid0");
      cyc(1'b1, 11'h032, 1'b1, 11'h031, 1'b1, 1'b0, "mid1");
      cyc(1'b1, 11'h033, 1'b1, 11'h031, 1'b1, 1'b0, "mid2");
      chk("mid.wait_cnt_pre", 64'(dut.wait_cnt_q), 64'h3);
      rst_ni        = 1'b0;
      bus.h0_req_i  = 1'b0;
      bus.h1_req_i  = 1'b0;
      bus.h0_addr_i = '0;
      bus.h1_addr_i = '0;
      #1;
      chk("mid.rvalid",   64'({bus.h0_rvalid_o, bus.h1_rvalid_o}), 64'h0);
      chk("mid.rdata",    64'(bus.h0_rdata_o | bus.h1_rdata_o), 64'h0);
      chk("mid.rsp_err",  64'(bus.rsp_err_o),  64'h0);
      chk("mid.wait_cnt", 64'(dut.wait_cnt_q), 64'h0);
      chk("mid.rom_req",  64'(bus.rom_req_o),  64'h0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      sb.delete();
      sb.push_back('{vld: 1'b0, host: 1'b0, data: 32'h0, err: 1'b0});
      cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, "post0");
      cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, "post1");
      cyc(1'b1, 11'h7FF, 1'b0, 11'h000, 1'b1, 1'b0, "post_rd");
      cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, "post_rsp");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
